// File: rtl/ex_alu_muldiv.sv
// Execute stage for RV32I/RV32M, XLEN-generic.
// Single-cycle ALU for OP / OP-IMM, plus an iterative sign-magnitude
// multiply / restoring-divide engine retiring BITS_PER_CYCLE bits per cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer keeps valid and payload steady until that edge. The
// consumer may raise or lower ready at any time. Upstream: accept =
// in_valid && in_ready && !flush_i, and operands are captured on that edge.
// Downstream: out_valid/rd_* hold steady until out_ready. in_ready is high in
// IDLE, and in DONE when the held result is being drained in the same cycle.
module ex_alu_muldiv #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            rd_we_i,
    input  logic [4:0]      rd_addr_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic [1:0]      state_dbg
);

    localparam logic [6:0]      OP_R      = 7'b0110011;
    localparam logic [6:0]      OP_I_IMM  = 7'b0010011;
    localparam logic [6:0]      F7_MULDIV = 7'b0000001;
    localparam int              SHW       = $clog2(XLEN);
    localparam int              ITERS     = XLEN / BITS_PER_CYCLE;
    localparam int              CW        = $clog2(ITERS) + 1;
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // Decode and single-cycle results
    logic            is_op_r, is_op_imm, is_m, div_op;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic            div_by_zero, div_ovf, is_fast, is_slow;
    logic [XLEN-1:0] op_b, alu_res, sra_res, fast_res, single_res;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [SHW-1:0]  shamt;

    // Iterative engine state
    logic [CW-1:0]     count;
    logic              eng_div, eng_want_hi, eng_want_rem, eng_neg_q, eng_neg_r;
    logic [XLEN-1:0]   eng_mcand, eng_work, eng_rem;
    logic [2*XLEN-1:0] eng_prod;

    // One iteration's worth of engine update, and the finished result
    logic [XLEN-1:0]   it_work, it_rem, quot_fix, rem_fix, m_res;
    logic [XLEN:0]     it_trial;
    logic [2*XLEN-1:0] it_prod, prod_fix;

    logic accept;

    // Decode the request and compute every one-cycle result
    always_comb begin
        is_op_r   = (opcode_i == OP_R);
        is_op_imm = (opcode_i == OP_I_IMM);
        is_m      = is_op_r && (funct7_i == F7_MULDIV);
        op_b      = is_op_r ? rs2_data_i : imm_i;
        shamt     = op_b[SHW-1:0];
        sra_res   = $signed(rs1_data_i) >>> shamt;
        alu_res   = '0;
        case (funct3_i)
            3'b000: begin
                if (is_op_r && funct7_i[5]) alu_res = rs1_data_i - op_b;
                else                        alu_res = rs1_data_i + op_b;
            end
            3'b001: alu_res = rs1_data_i << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data_i) < $signed(op_b))};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (rs1_data_i < op_b)};
            3'b100: alu_res = rs1_data_i ^ op_b;
            3'b101: begin
                if (funct7_i[5]) alu_res = sra_res;
                else             alu_res = rs1_data_i >> shamt;
            end
            3'b110: alu_res = rs1_data_i | op_b;
            default: alu_res = rs1_data_i & op_b;
        endcase

        // M-extension operand signedness: MULH both, MULHSU rs1 only, DIV/REM both
        div_op   = funct3_i[2];
        a_signed = div_op ? ~funct3_i[0] : ((funct3_i == 3'b001) || (funct3_i == 3'b010));
        b_signed = div_op ? ~funct3_i[0] : (funct3_i == 3'b001);
        a_neg    = a_signed && rs1_data_i[XLEN-1];
        b_neg    = b_signed && rs2_data_i[XLEN-1];
        a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
        b_mag    = b_neg ? -rs2_data_i : rs2_data_i;

        // Division corner cases bypass the engine
        div_by_zero = (rs2_data_i == '0);
        div_ovf     = ~funct3_i[0] && (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
        is_fast     = is_m && div_op && (div_by_zero || div_ovf);
        is_slow     = is_m && !is_fast;
        if (div_by_zero) fast_res = funct3_i[1] ? rs1_data_i : '1;
        else             fast_res = funct3_i[1] ? '0 : rs1_data_i;

        if (is_fast)                     single_res = fast_res;
        else if (is_op_r || is_op_imm)   single_res = alu_res;
        else                             single_res = '0;
    end

    // Engine step: BITS_PER_CYCLE shift-add or restoring-subtract steps, MSB first
    always_comb begin
        it_prod  = eng_prod;
        it_work  = eng_work;
        it_rem   = eng_rem;
        it_trial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (eng_div) begin
                it_trial = {it_rem, it_work[XLEN-1]};
                it_work  = {it_work[XLEN-2:0], 1'b0};
                if (it_trial >= {1'b0, eng_mcand}) begin
                    it_trial   = it_trial - {1'b0, eng_mcand};
                    it_work[0] = 1'b1;
                end
                it_rem = it_trial[XLEN-1:0];
            end else begin
                it_prod = {it_prod[2*XLEN-2:0], 1'b0}
                        + (it_work[XLEN-1] ? {{XLEN{1'b0}}, eng_mcand} : {(2*XLEN){1'b0}});
                it_work = {it_work[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign-correct the last step's magnitudes into the architectural result
    always_comb begin
        prod_fix = eng_neg_q ? -it_prod : it_prod;
        quot_fix = eng_neg_q ? -it_work : it_work;
        rem_fix  = eng_neg_r ? -it_rem  : it_rem;
        if (eng_div)          m_res = eng_want_rem ? rem_fix : quot_fix;
        else if (eng_want_hi) m_res = prod_fix[2*XLEN-1:XLEN];
        else                  m_res = prod_fix[XLEN-1:0];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // FSM next state and handshake outputs; flush overrides everything
    always_comb begin
        state_next = state;
        in_ready   = (state == S_IDLE) || ((state == S_DONE) && out_ready);
        out_valid  = (state == S_DONE);
        state_dbg  = state;
        accept     = in_valid && in_ready && !flush_i;
        case (state)
            S_IDLE: if (accept) state_next = is_slow ? S_BUSY : S_DONE;
            S_BUSY: if (count == '0) state_next = S_DONE;
            S_DONE: begin
                if (accept)         state_next = is_slow ? S_BUSY : S_DONE;
                else if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush_i) state_next = S_IDLE;
    end

    // Capture requests, run the engine, and hold the registered result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_we        <= 1'b0;
            rd_addr      <= '0;
            rd_data      <= '0;
            count        <= '0;
            eng_div      <= 1'b0;
            eng_want_hi  <= 1'b0;
            eng_want_rem <= 1'b0;
            eng_neg_q    <= 1'b0;
            eng_neg_r    <= 1'b0;
            eng_mcand    <= '0;
            eng_work     <= '0;
            eng_rem      <= '0;
            eng_prod     <= '0;
        end else if (flush_i) begin
            rd_we <= 1'b0;
        end else if (accept) begin
            rd_addr <= rd_addr_i;
            rd_we   <= rd_we_i && (is_op_r || is_op_imm);
            if (is_slow) begin
                count        <= CW'(ITERS - 1);
                eng_div      <= div_op;
                eng_want_hi  <= (funct3_i[1:0] != 2'b00);
                eng_want_rem <= funct3_i[1];
                eng_neg_q    <= a_neg ^ b_neg;
                eng_neg_r    <= a_neg;
                eng_work     <= a_mag;
                eng_mcand    <= b_mag;
                eng_rem      <= '0;
                eng_prod     <= '0;
            end else begin
                rd_data <= single_res;
            end
        end else if (state == S_BUSY) begin
            eng_prod <= it_prod;
            eng_work <= it_work;
            eng_rem  <= it_rem;
            count    <= count - 1'b1;
            if (count == '0) rd_data <= m_res;
        end
    end

endmodule
